// File: rtl/uart_rx_framed.sv
// UART receiver with 3-sample majority vote, optional parity, 1 or 2 stop bits,
// and a one-entry valid/ready holding register with per-word error flags.
module uart_rx_framed #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int S_W      = $clog2(OVERSAMPLE);
    localparam int BIT_MAX  = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int BIT_W    = $clog2(BIT_MAX);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [S_W-1:0]    S_V0      = S_W'(OVERSAMPLE / 2 - 1);
    localparam logic [S_W-1:0]    S_V1      = S_W'(OVERSAMPLE / 2);
    localparam logic [S_W-1:0]    S_V2      = S_W'(OVERSAMPLE / 2 + 1);
    localparam logic [S_W-1:0]    S_LAST    = S_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    generate
        if (TICK_DIV < 1) begin : g_bad_tick_div
            $error("uart_rx_framed: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
        end
        if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
            $error("uart_rx_framed: OVERSAMPLE must be even and >= 8");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_rx_framed: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_rx_framed: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_rx_framed: STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t               state, state_next;
    logic                 rx_meta, rx_sync;
    logic [TICK_W-1:0]    tick_cnt;
    logic [S_W-1:0]       s_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 smp0, smp1;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr, ferr;
    logic                 tick, vote, at_mid, at_end, frame_done;

    // Majority of three line samples taken around the bit centre
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter should have sent for the given word
    function automatic logic expected_parity(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    assign tick       = (tick_cnt == TICK_LAST);
    assign vote       = majority3(smp0, smp1, rx_sync);
    assign at_mid     = tick && (s_cnt == S_V2);
    assign at_end     = tick && (s_cnt == S_LAST);
    assign frame_done = (state == ST_STOP) && at_mid && (bit_cnt == STOP_LAST);
    assign o_busy     = (state != ST_IDLE);

    // Two-flop synchroniser for the asynchronous line; idles high
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic; a high vote at mid start bit is treated as a glitch
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (!rx_sync) state_next = ST_START;
            ST_START: begin
                if (at_mid && vote) state_next = ST_IDLE;
                else if (at_end)    state_next = ST_DATA;
            end
            ST_DATA:   if (at_end && bit_cnt == DATA_LAST)
                           state_next = (PARITY != 0) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (at_end) state_next = ST_STOP;
            ST_STOP:   if (frame_done) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Tick, sample and bit counters; held at zero in IDLE so every frame starts aligned
    always_ff @(posedge clk) begin
        if (!reset_n || state == ST_IDLE) begin
            tick_cnt <= '0;
            s_cnt    <= '0;
            bit_cnt  <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) begin
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
                if (s_cnt == S_LAST)
                    bit_cnt <= (state_next != state) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    // Capture the first two of the three vote samples; the third is the live line
    always_ff @(posedge clk) begin
        if (tick) begin
            if (s_cnt == S_V0) smp0 <= rx_sync;
            if (s_cnt == S_V1) smp1 <= rx_sync;
        end
    end

    // Shift in data LSB first and accumulate per-frame error flags
    always_ff @(posedge clk) begin
        if (!reset_n || state == ST_IDLE) begin
            perr <= 1'b0;
            ferr <= 1'b0;
        end else if (at_mid) begin
            case (state)
                ST_DATA:   shreg <= {vote, shreg[DATA_BITS-1:1]};
                ST_PARITY: if (vote != expected_parity(shreg)) perr <= 1'b1;
                ST_STOP:   if (!vote) ferr <= 1'b1;
                default:   ;
            endcase
        end
    end

    // Holding register: a completed frame loads if empty or being drained, else it is dropped
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= 1'b0;
            if (frame_done && (!o_valid || i_ready)) begin
                o_data       <= shreg;
                o_valid      <= 1'b1;
                o_parity_err <= perr;
                o_frame_err  <= ferr | ~vote;
            end else if (frame_done) begin
                o_overrun <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid      <= 1'b0;
                o_parity_err <= 1'b0;
                o_frame_err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: four instances (8N1, 8E1, 8N2, 5N1) at 160 clk/bit,
// a vector table of single frames plus directed overrun, false-start and reset sequences.
module tb_uart_rx_framed;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] rx, rdy, vld, perr, ferr, ovr, busy;
    logic [7:0] d0, d1, d2;
    logic [4:0] d3;
    logic [8:0] dx [4];

    int         acc_cnt  [4] = '{0, 0, 0, 0};
    int         ovr_cnt  [4] = '{0, 0, 0, 0};
    logic [8:0] acc_data [4];
    logic       acc_p    [4];
    logic       acc_f    [4];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         k;
        logic [8:0] d;
        int         par;
        logic [1:0] stops;
        logic [8:0] ed;
        logic       ep;
        logic       ef;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    always #5 clk = ~clk;

    uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                     .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset_n(reset_n), .i_rx(rx[0]), .o_data(d0), .o_valid(vld[0]),
        .i_ready(rdy[0]), .o_parity_err(perr[0]), .o_frame_err(ferr[0]),
        .o_overrun(ovr[0]), .o_busy(busy[0]));

    uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                     .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset_n(reset_n), .i_rx(rx[1]), .o_data(d1), .o_valid(vld[1]),
        .i_ready(rdy[1]), .o_parity_err(perr[1]), .o_frame_err(ferr[1]),
        .o_overrun(ovr[1]), .o_busy(busy[1]));

    uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                     .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset_n(reset_n), .i_rx(rx[2]), .o_data(d2), .o_valid(vld[2]),
        .i_ready(rdy[2]), .o_parity_err(perr[2]), .o_frame_err(ferr[2]),
        .o_overrun(ovr[2]), .o_busy(busy[2]));

    uart_rx_framed #(.CLK_FREQ(1_600_000), .BAUD_RATE(10_000), .OVERSAMPLE(16),
                     .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_5n1 (
        .clk(clk), .reset_n(reset_n), .i_rx(rx[3]), .o_data(d3), .o_valid(vld[3]),
        .i_ready(rdy[3]), .o_parity_err(perr[3]), .o_frame_err(ferr[3]),
        .o_overrun(ovr[3]), .o_busy(busy[3]));

    always_comb begin
        dx[0] = {1'b0, d0};
        dx[1] = {1'b0, d1};
        dx[2] = {1'b0, d2};
        dx[3] = {4'b0, d3};
    end

    // Record every accepted word and count overrun cycles per instance
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (vld[k] && rdy[k]) begin
                acc_cnt[k]  <= acc_cnt[k] + 1;
                acc_data[k] <= dx[k];
                acc_p[k]    <= perr[k];
                acc_f[k]    <= ferr[k];
            end
            if (ovr[k]) ovr_cnt[k] <= ovr_cnt[k] + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one frame: start bit, data LSB first, optional parity bit, stop bits
    task automatic send_frame(input int k, input logic [8:0] d, input int nd, input int par,
                              input logic [1:0] stops, input int ns);
        logic [15:0] bits;
        int n;
        bits = '1;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < nd; i++) begin bits[n] = d[i]; n++; end
        if (par >= 0) begin bits[n] = (par != 0); n++; end
        for (int i = 0; i < ns; i++) begin bits[n] = stops[i]; n++; end
        for (int i = 0; i < n; i++) begin
            rx[k] = bits[i];
            repeat (160) @(posedge clk);
            #1;
        end
        rx[k] = 1'b1;
    endtask

    initial begin
        int a0, o0, k;

        vt[0]  = '{0, 9'h0A5, -1, 2'b01, 9'h0A5, 1'b0, 1'b0};
        vt[1]  = '{1, 9'h003,  1, 2'b01, 9'h003, 1'b1, 1'b0};
        vt[2]  = '{1, 9'h003,  0, 2'b01, 9'h003, 1'b0, 1'b0};
        vt[3]  = '{0, 9'h05A, -1, 2'b00, 9'h05A, 1'b0, 1'b1};
        vt[4]  = '{2, 9'h05A, -1, 2'b01, 9'h05A, 1'b0, 1'b1};
        vt[5]  = '{2, 9'h03C, -1, 2'b11, 9'h03C, 1'b0, 1'b0};
        vt[6]  = '{3, 9'h015, -1, 2'b01, 9'h015, 1'b0, 1'b0};
        vt[7]  = '{1, 9'h096,  0, 2'b01, 9'h096, 1'b0, 1'b0};
        vt[8]  = '{1, 9'h001,  0, 2'b01, 9'h001, 1'b1, 1'b0};
        vt[9]  = '{0, 9'h000, -1, 2'b01, 9'h000, 1'b0, 1'b0};
        vt[10] = '{0, 9'h0FF, -1, 2'b01, 9'h0FF, 1'b0, 1'b0};
        vt[11] = '{3, 9'h00A, -1, 2'b01, 9'h00A, 1'b0, 1'b0};

        reset_n = 1'b0;
        rx  = '1;
        rdy = '1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", {28'b0, vld}, 32'h0);
        chk("rst_busy", {28'b0, busy}, 32'h0);
        chk("rst_perr", {28'b0, perr}, 32'h0);
        chk("rst_ferr", {28'b0, ferr}, 32'h0);
        chk("rst_ovr", {28'b0, ovr}, 32'h0);
        chk("rst_data0", {24'b0, d0}, 32'h0);
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            k  = vt[i].k;
            a0 = acc_cnt[k];
            send_frame(k, vt[i].d, (k == 3) ? 5 : 8, vt[i].par, vt[i].stops, (k == 2) ? 2 : 1);
            repeat (300) @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_count", i), acc_cnt[k] - a0, 1);
            chk($sformatf("v%0d_data", i), {23'b0, acc_data[k]}, {23'b0, vt[i].ed});
            chk($sformatf("v%0d_perr", i), {31'b0, acc_p[k]}, {31'b0, vt[i].ep});
            chk($sformatf("v%0d_ferr", i), {31'b0, acc_f[k]}, {31'b0, vt[i].ef});
            chk($sformatf("v%0d_busy", i), {31'b0, busy[k]}, 32'h0);
            chk($sformatf("v%0d_valid", i), {31'b0, vld[k]}, 32'h0);
            @(posedge clk); #1;
        end

        // False start: 40-clock low pulse
        a0 = acc_cnt[0];
        rx[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("fs_busy_high", {31'b0, busy[0]}, 32'h1);
        repeat (30) @(posedge clk);
        #1 rx[0] = 1'b1;
        for (int c = 0; c < 100 && busy[0]; c++) @(posedge clk);
        #1 chk("fs_busy_low", {31'b0, busy[0]}, 32'h0);
        repeat (200) @(posedge clk);
        #1 chk("fs_no_word", acc_cnt[0] - a0, 0);
        chk("fs_no_valid", {31'b0, vld[0]}, 32'h0);

        // Overrun: two back-to-back frames with the consumer stalled
        rdy[0] = 1'b0;
        a0 = acc_cnt[0];
        o0 = ovr_cnt[0];
        send_frame(0, 9'h011, 8, -1, 2'b01, 1);
        send_frame(0, 9'h022, 8, -1, 2'b01, 1);
        repeat (100) @(posedge clk);
        @(negedge clk);
        chk("ovr_pulse_cycles", ovr_cnt[0] - o0, 1);
        chk("ovr_valid_held", {31'b0, vld[0]}, 32'h1);
        chk("ovr_data_held", {24'b0, d0}, 32'h11);
        chk("ovr_none_accepted", acc_cnt[0] - a0, 0);
        @(posedge clk); #1 rdy[0] = 1'b1;
        @(posedge clk); #1;
        chk("ovr_valid_cleared", {31'b0, vld[0]}, 32'h0);
        chk("ovr_accept_count", acc_cnt[0] - a0, 1);
        chk("ovr_accept_data", {23'b0, acc_data[0]}, 32'h11);

        // Reset during data bit 3 with a word held in the output register
        rdy[0] = 1'b0;
        send_frame(0, 9'h044, 8, -1, 2'b01, 1);
        repeat (100) @(posedge clk);
        #1 chk("mr_held_before", {31'b0, vld[0]}, 32'h1);
        a0 = acc_cnt[0];
        fork
            send_frame(0, 9'h0FF, 8, -1, 2'b01, 1);
            begin
                repeat (720) @(posedge clk);
                #1 reset_n = 1'b0;
                @(posedge clk); #1;
                chk("mr_valid", {31'b0, vld[0]}, 32'h0);
                chk("mr_data", {24'b0, d0}, 32'h0);
                chk("mr_busy", {31'b0, busy[0]}, 32'h0);
                chk("mr_flags", {29'b0, perr[0], ferr[0], ovr[0]}, 32'h0);
                reset_n = 1'b1;
            end
        join
        repeat (300) @(posedge clk);
        #1 chk("mr_abandoned", {31'b0, vld[0]}, 32'h0);
        chk("mr_no_accept", acc_cnt[0] - a0, 0);
        rdy[0] = 1'b1;
        send_frame(0, 9'h0C3, 8, -1, 2'b01, 1);
        repeat (300) @(posedge clk);
        @(negedge clk);
        chk("mr_next_count", acc_cnt[0] - a0, 1);
        chk("mr_next_data", {23'b0, acc_data[0]}, 32'hC3);
        chk("mr_next_flags", {30'b0, acc_p[0], acc_f[0]}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
